d_ff_sipo_deserializer: RTL and testbench

- Serial-in/parallel-out deserializer built from a chain of D flip-flops.
- Sits downstream of the single-bit D flip-flop stage: consumes its registered serial bit stream, assembles WIDTH-bit words and presents them on a valid/ready output port.
- One-word output holding register plus the shift register: a full word can wait in each while downstream stalls. Upstream is back-pressured only when both are occupied.

---
 rtl/ff_pkg.sv | 17 +
 rtl/d_ff_en_rst.sv | 16 +
 rtl/d_ff_sipo_deserializer.sv | 128 ++++++++++++
 tb/tb_d_ff_sipo_deserializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared definitions for the D flip-flop based serial blocks:
// deserializer state encoding and the bit counter width helper.
package ff_pkg;

  // Deserializer control states. COLLECT gathers bits; STALL parks a
  // completed word in the shift register while the output is still full.
  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  // Width of a counter that must hold 0 .. w-1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/d_ff_en_rst.sv
// Single D flip-flop with synchronous active-high reset and load enable.
module d_ff_en_rst (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Reset wins; otherwise load d only when enabled.
  always_ff @(posedge clk) begin
    if (rst)     q <= 1'b0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/d_ff_sipo_deserializer.sv
// Serial-in/parallel-out deserializer. A shift register of D flip-flops
// assembles WIDTH-bit words which are moved into a one-word output
// register and offered on a valid/ready port. A second finished word may
// wait in the shift register (STALL) while the output is still occupied.
module d_ff_sipo_deserializer
  import ff_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic                        flush,
  output logic [WIDTH-1:0]            dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [cnt_w(WIDTH)-1:0]     bit_cnt
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] out_d;
  logic             sr_en;
  logic             out_en;
  logic             accept;
  logic             consume;
  logic             complete;

  // Ready depends on state only so upstream never sees a valid->ready loop.
  assign din_ready = (state == COLLECT) && !rst;
  assign accept    = din_valid && din_ready;
  assign consume   = dout_valid && dout_ready;

  // Next shift-register content with the new bit inserted.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_shift = {sr_q[WIDTH-2:0], din};
    end else begin : g_lsb
      assign sr_shift = {din, sr_q[WIDTH-1:1]};
    end
  endgenerate

  // A word completes on the last accepted bit unless flush cancels it.
  assign complete = accept && !flush && (bit_cnt == LAST);

  // Shift-register and output-register load control.
  always_comb begin
    sr_d   = '0;
    sr_en  = 1'b0;
    out_d  = sr_shift;
    out_en = 1'b0;
    if (state == COLLECT) begin
      if (flush) begin
        sr_d  = '0;
        sr_en = 1'b1;
      end else if (accept) begin
        sr_d  = sr_shift;
        sr_en = 1'b1;
        // Completed word goes straight to the output if that slot frees up.
        if (complete && (!dout_valid || dout_ready)) out_en = 1'b1;
      end
    end else begin
      // Stalled word moves to the output as soon as the old one is taken.
      out_d  = sr_q;
      out_en = consume;
    end
  end

  // Shift register and output register, one flop per bit each.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_ff_en_rst u_sr (
        .clk (clk),
        .rst (rst),
        .en  (sr_en),
        .d   (sr_d[i]),
        .q   (sr_q[i])
      );
      d_ff_en_rst u_out (
        .clk (clk),
        .rst (rst),
        .en  (out_en),
        .d   (out_d[i]),
        .q   (dout[i])
      );
    end
  endgenerate

  // Control FSM: bit counter, output valid flag and COLLECT/STALL state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      bit_cnt    <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (flush) begin
            // Partial word dropped; output handshake carries on untouched.
            bit_cnt <= '0;
            if (consume) dout_valid <= 1'b0;
          end else if (accept && (bit_cnt == LAST)) begin
            bit_cnt <= '0;
            if (!dout_valid || dout_ready) dout_valid <= 1'b1;
            else                           state      <= STALL;
          end else begin
            if (accept)  bit_cnt    <= bit_cnt + CW'(1);
            if (consume) dout_valid <= 1'b0;
          end
        end
        STALL: begin
          // dout_valid stays high: the parked word replaces the consumed one.
          if (consume) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_d_ff_sipo_deserializer.sv
// Directed bench for d_ff_sipo_deserializer. Two instances (MSB-first and
// LSB-first) see identical stimulus; every word sent pushes its expected
// value for each instance, and words are popped and compared on consume.
module tb_d_ff_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       flush;
  logic       dout_ready;

  logic       rdy_m, rdy_l;
  logic [7:0] dout_m, dout_l;
  logic       vld_m, vld_l;
  logic [2:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  d_ff_sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .flush(flush), .dout(dout_m), .dout_valid(vld_m), .dout_ready(dout_ready),
    .bit_cnt(cnt_m)
  );

  d_ff_sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .flush(flush), .dout(dout_l), .dout_valid(vld_l), .dout_ready(dout_ready),
    .bit_cnt(cnt_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard + ready), return 1ns after posedge.
  task automatic tick(output logic acc);
    logic [7:0] e;
    @(negedge clk);
    acc = rdy_m;
    if (vld_m && dout_ready) begin
      checks++;
      assert (q_m.size() != 0) else begin
        errors++;
        $error("FAIL sb_msb_empty observed %0h expected none", dout_m);
      end
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        chk("sb_msb", dout_m, e);
      end
    end
    if (vld_l && dout_ready) begin
      checks++;
      assert (q_l.size() != 0) else begin
        errors++;
        $error("FAIL sb_lsb_empty observed %0h expected none", dout_l);
      end
      if (q_l.size() != 0) begin
        e = q_l.pop_front();
        chk("sb_lsb", dout_l, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    din_valid = 1'b0;
    repeat (n) tick(a);
  endtask

  // Offer one bit until accepted, bounded.
  task automatic send_bit(input logic b);
    logic acc;
    acc = 1'b0;
    din = b;
    din_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) tick(acc);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout observed 0 expected 1");
    end
    din_valid = 1'b0;
  endtask

  // Send s[7] first. MSB-first instance rebuilds s, LSB-first its reverse.
  task automatic send_word(input logic [7:0] s, input bit push);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = s[7-i];
    if (push) begin
      q_m.push_back(s);
      q_l.push_back(r);
    end
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
  endtask

  initial begin
    logic a;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;

    // Reset
    @(posedge clk); #1;
    chk("rst_rdy_low", rdy_m, 1'b0);
    chk("rst_dout", dout_m, 8'h00);
    chk("rst_vld", vld_m, 1'b0);
    chk("rst_cnt", cnt_m, 3'd0);
    rst = 1'b0; #1;
    chk("rst_rdy_high", rdy_m, 1'b1);
    @(posedge clk); #1;

    // Back-to-back words, dout_ready=1
    send_word(8'hA5, 1'b1);
    chk("a5_vld", vld_m, 1'b1);
    chk("a5_msb", dout_m, 8'hA5);
    chk("a5_lsb", dout_l, 8'hA5);
    send_word(8'hC0, 1'b1);
    chk("c0_msb", dout_m, 8'hC0);
    chk("c0_lsb", dout_l, 8'h03);
    chk("c0_vld", vld_l, 1'b1);
    idle(1);
    chk("one_cycle_vld", vld_m, 1'b0);

    // Stall: two words with no consumer
    dout_ready = 1'b0;
    send_word(8'hF0, 1'b1);
    send_word(8'h0F, 1'b1);
    chk("stall_dout", dout_m, 8'hF0);
    chk("stall_vld", vld_m, 1'b1);
    chk("stall_rdy", rdy_m, 1'b0);
    din = 1'b1; din_valid = 1'b1; flush = 1'b1;
    tick(a);
    tick(a);
    flush = 1'b0; din_valid = 1'b0;
    chk("stall_flush_rdy", rdy_m, 1'b0);
    chk("stall_flush_cnt", cnt_m, 3'd0);
    chk("stall_hold_dout", dout_m, 8'hF0);
    dout_ready = 1'b1;
    tick(a);
    dout_ready = 1'b0;
    chk("unstall_dout_m", dout_m, 8'h0F);
    chk("unstall_dout_l", dout_l, 8'hF0);
    chk("unstall_vld", vld_m, 1'b1);
    chk("unstall_rdy", rdy_m, 1'b1);
    idle(1);
    chk("unstall_hold_vld", vld_m, 1'b1);
    dout_ready = 1'b1;
    idle(1);
    chk("unstall_drain", vld_m, 1'b0);

    // Flush mid-word with a bit offered
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("pre_flush_cnt", cnt_m, 3'd3);
    din = 1'b1; din_valid = 1'b1; flush = 1'b1;
    tick(a);
    flush = 1'b0; din_valid = 1'b0;
    chk("flush_cnt", cnt_m, 3'd0);
    send_word(8'h3C, 1'b1);
    chk("flush_word", dout_m, 8'h3C);
    idle(1);

    // Flush against a completing bit: no word
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    din = 1'b1; din_valid = 1'b1; flush = 1'b1;
    tick(a);
    flush = 1'b0; din_valid = 1'b0;
    chk("flush_complete_vld", vld_m, 1'b0);
    chk("flush_complete_cnt", cnt_m, 3'd0);

    // Reset mid-word while a word waits on the output
    dout_ready = 1'b0;
    send_word(8'h77, 1'b0);
    chk("pre_rst_vld", vld_m, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("pre_rst_cnt", cnt_m, 3'd5);
    rst = 1'b1; #1;
    chk("rst_mid_rdy", rdy_m, 1'b0);
    tick(a);
    chk("rst_mid_dout", dout_m, 8'h00);
    chk("rst_mid_vld", vld_m, 1'b0);
    chk("rst_mid_cnt", cnt_m, 3'd0);
    rst = 1'b0;
    dout_ready = 1'b1;
    send_word(8'h5A, 1'b1);
    chk("post_rst_word", dout_m, 8'h5A);
    chk("post_rst_lsb", dout_l, 8'h5A);
    idle(2);

    chk("sb_msb_left", q_m.size(), 0);
    chk("sb_lsb_left", q_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
